axi4lite_cmd_master: RTL and testbench

Single-outstanding AXI4-Lite master that turns a simple valid/ready command stream (read or write, 12-bit byte address, 32-bit data, byte strobes) into AXI4-Lite transactions and returns one response per command. It sits directly upstream of the register bank and drives its ctrl_* slave port, typically fed by a host/debug command decoder. It also keeps a saturating count of non-OKAY responses for status.

---
 rtl/axi4lite_cmd_master.sv | 257 +++++++++++++++++++++++++
 tb/tb_axi4lite_cmd_master.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_cmd_master.sv
// axi4lite_cmd_master
// Turns a valid/ready command stream (read or write) into single-outstanding
// AXI4-Lite transactions and returns exactly one response per command. A
// saturating count of non-OKAY responses is kept for status.
//
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_write/addr/wdata/wstrb    command payload (wdata/wstrb unused on reads)
//   rsp_valid/rsp_ready           response handshake
//   rsp_write/rdata/resp          response payload (rdata is 0 for writes)
//   m_ar*/m_r*/m_aw*/m_w*/m_b*    AXI4-Lite master channels
//   err_count                     saturating count of non-OKAY responses
module axi4lite_cmd_master #(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  // command stream
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [31:0]              cmd_wdata,
  input  logic [3:0]               cmd_wstrb,
  // response stream
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic [31:0]              rsp_rdata,
  output logic [1:0]               rsp_resp,
  // AR channel
  output logic                     m_arvalid,
  input  logic                     m_arready,
  output logic [ADDR_WIDTH-1:0]    m_araddr,
  // R channel
  input  logic                     m_rvalid,
  output logic                     m_rready,
  input  logic [31:0]              m_rdata,
  input  logic [1:0]               m_rresp,
  // AW channel
  output logic                     m_awvalid,
  input  logic                     m_awready,
  output logic [ADDR_WIDTH-1:0]    m_awaddr,
  // W channel
  output logic                     m_wvalid,
  input  logic                     m_wready,
  output logic [31:0]              m_wdata,
  output logic [3:0]               m_wstrb,
  // B channel
  input  logic                     m_bvalid,
  output logic                     m_bready,
  input  logic [1:0]               m_bresp,
  // status
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned RESP_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_RSP
  } state_e;

  state_e                   state_q,   state_d;
  logic                     write_q,   write_d;
  logic [ADDR_WIDTH-1:0]    addr_q,    addr_d;
  logic [DATA_W-1:0]        wdata_q,   wdata_d;
  logic [STRB_W-1:0]        wstrb_q,   wstrb_d;
  logic                     arvalid_q, arvalid_d;
  logic                     rready_q,  rready_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q,  wvalid_d;
  logic                     bready_q,  bready_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q,  w_done_d;
  logic                     rvalid_q,  rvalid_d;
  logic [DATA_W-1:0]        rdata_q,   rdata_d;
  logic [RESP_W-1:0]        resp_q,    resp_d;
  logic [ERR_CNT_WIDTH-1:0] err_q,     err_d;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic aw_done_n, w_done_n, err_inc;

  assign ar_hs = arvalid_q & m_arready;
  assign r_hs  = rready_q  & m_rvalid;
  assign aw_hs = awvalid_q & m_awready;
  assign w_hs  = wvalid_q  & m_wready;
  assign b_hs  = bready_q  & m_bvalid;

  // Ready is decoded from state but gated by reset so it is low while held.
  assign cmd_ready = (state_q == S_IDLE) && aresetn;

  assign m_arvalid = arvalid_q;
  assign m_araddr  = addr_q;
  assign m_rready  = rready_q;
  assign m_awvalid = awvalid_q;
  assign m_awaddr  = addr_q;
  assign m_wvalid  = wvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_bready  = bready_q;
  assign rsp_valid = rvalid_q;
  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign err_count = err_q;

  // State and output registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
    end
  end

  // Next-state and next-output logic; every valid/ready is computed one
  // cycle ahead so it leaves a flop and never depends on a same-cycle ready.
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    err_d     = err_q;
    aw_done_n = aw_done_q | aw_hs;
    w_done_n  = w_done_q | w_hs;
    err_inc   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end

      S_RD_ADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        if (r_hs) begin
          rready_d = 1'b0;
          rdata_d  = m_rdata;
          resp_d   = m_rresp;
          err_inc  = (m_rresp != 2'b00);
          rvalid_d = 1'b1;
          state_d  = S_RSP;
        end
      end

      // AW and W complete independently; leave only once both are done.
      S_WR_REQ: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (aw_done_n && w_done_n) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = S_WR_RESP;
        end else begin
          aw_done_d = aw_done_n;
          w_done_d  = w_done_n;
        end
      end

      S_WR_RESP: begin
        if (b_hs) begin
          bready_d = 1'b0;
          rdata_d  = '0;
          resp_d   = m_bresp;
          err_inc  = (m_bresp != 2'b00);
          rvalid_d = 1'b1;
          state_d  = S_RSP;
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Saturating error counter: hold at all-ones instead of wrapping.
    if (err_inc && (err_q != {ERR_CNT_WIDTH{1'b1}})) begin
      err_d = err_q + ERR_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Directed bench for axi4lite_cmd_master with a small register-bank-like
// AXI4-Lite slave (configurable AW/W ready delays and read response code).
module tb_axi4lite_cmd_master;

  localparam int unsigned AW = 12;
  localparam int unsigned EW = 2;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_write;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          m_arvalid;
  logic          m_arready = 1'b0;
  logic [AW-1:0] m_araddr;
  logic          m_rvalid = 1'b0;
  logic          m_rready;
  logic [31:0]   m_rdata = '0;
  logic [1:0]    m_rresp = '0;
  logic          m_awvalid;
  logic          m_awready = 1'b0;
  logic [AW-1:0] m_awaddr;
  logic          m_wvalid;
  logic          m_wready = 1'b0;
  logic [31:0]   m_wdata;
  logic [3:0]    m_wstrb;
  logic          m_bvalid = 1'b0;
  logic          m_bready;
  logic [1:0]    m_bresp = '0;
  logic [EW-1:0] err_count;

  int vectors = 0;
  int miscompares = 0;

  // slave configuration and state
  int          aw_lat = 0;
  int          w_lat = 0;
  int          aw_wait = 0;
  int          w_wait = 0;
  logic [1:0]  rresp_cfg = 2'b00;
  logic        rd_pend = 1'b0;
  logic [11:0] rd_addr = '0;
  logic        aw_got = 1'b0;
  logic        w_got = 1'b0;
  logic [11:0] aw_addr_r = '0;
  logic [31:0] wd_r = '0;
  logic [3:0]  ws_r = '0;
  logic        b_pend = 1'b0;
  logic        aw_now, w_now;
  logic [11:0] wa;
  logic [31:0] wd;
  logic [3:0]  ws;
  logic [31:0] mem [0:1023];

  int ar_hs_cnt = 0;
  int aw_hs_cnt = 0;
  int w_hs_cnt = 0;
  int b_hs_cnt = 0;
  int rsp_hs_cnt = 0;

  always #5 clk = ~clk;

  axi4lite_cmd_master #(
    .ADDR_WIDTH   (AW),
    .ERR_CNT_WIDTH(EW)
  ) dut (
    .aclk      (clk),
    .aresetn   (aresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_araddr  (m_araddr),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_awaddr  (m_awaddr),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .m_bresp   (m_bresp),
    .err_count (err_count)
  );

  // Slave: observe handshakes at the active edge, commit writes, count traffic.
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rd_pend <= 1'b0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      b_pend  <= 1'b0;
    end else begin
      if (m_arvalid && m_arready) begin
        rd_pend   <= 1'b1;
        rd_addr   <= m_araddr;
        ar_hs_cnt <= ar_hs_cnt + 1;
      end else if (m_rvalid && m_rready) begin
        rd_pend <= 1'b0;
      end
      if (m_awvalid && m_awready) aw_hs_cnt <= aw_hs_cnt + 1;
      if (m_wvalid && m_wready)   w_hs_cnt  <= w_hs_cnt + 1;
      if (m_bvalid && m_bready) begin
        b_pend   <= 1'b0;
        b_hs_cnt <= b_hs_cnt + 1;
      end
      if (rsp_valid && rsp_ready) rsp_hs_cnt <= rsp_hs_cnt + 1;
      aw_now = aw_got || (m_awvalid && m_awready);
      w_now  = w_got || (m_wvalid && m_wready);
      wa = aw_got ? aw_addr_r : m_awaddr;
      wd = w_got ? wd_r : m_wdata;
      ws = w_got ? ws_r : m_wstrb;
      if (aw_now && w_now && !b_pend) begin
        for (int b = 0; b < 4; b++) begin
          if (ws[b]) mem[wa[11:2]][8*b +: 8] = wd[8*b +: 8];
        end
        b_pend <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (m_awvalid && m_awready) begin
          aw_got    <= 1'b1;
          aw_addr_r <= m_awaddr;
        end
        if (m_wvalid && m_wready) begin
          w_got <= 1'b1;
          wd_r  <= m_wdata;
          ws_r  <= m_wstrb;
        end
      end
    end
  end

  // Slave: drive its outputs on the falling edge, away from the DUT's sampling.
  always @(negedge clk) begin
    m_arready = m_arvalid;
    m_rvalid  = rd_pend;
    m_rdata   = rd_pend ? mem[rd_addr[11:2]] : 32'h0;
    m_rresp   = rd_pend ? rresp_cfg : 2'b00;
    if (m_awvalid) begin
      m_awready = (aw_wait >= aw_lat);
      aw_wait++;
    end else begin
      m_awready = 1'b0;
      aw_wait   = 0;
    end
    if (m_wvalid) begin
      m_wready = (w_wait >= w_lat);
      w_wait++;
    end else begin
      m_wready = 1'b0;
      w_wait   = 0;
    end
    m_bvalid = b_pend;
    m_bresp  = 2'b00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command at a falling edge in IDLE; return at the falling edge
  // where rsp_valid is first seen, with lat = cycles since acceptance.
  task automatic do_cmd(input logic wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_seen", rsp_valid, 1);
  endtask

  initial begin
    int lat;
    int cnt0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'hDEADBEEF;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_arvalid", m_arvalid, 0);
    check("rst_awvalid", m_awvalid, 0);
    check("rst_wvalid", m_wvalid, 0);
    check("rst_rready", m_rready, 0);
    check("rst_bready", m_bready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_resp", rsp_resp, 0);
    check("rst_araddr", m_araddr, 0);
    check("rst_err", err_count, 0);
    aresetn = 1'b1;
    #1;
    check("rel_cmd_ready", cmd_ready, 1);
    @(negedge clk);

    // Zero-wait read of 0x000, cycle by cycle
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h000;
    check("rd0_cmd_ready_n", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rd0_arvalid_n1", m_arvalid, 1);
    check("rd0_araddr_n1", m_araddr, 12'h000);
    check("rd0_cmd_ready_n1", cmd_ready, 0);
    @(negedge clk);
    check("rd0_rready_n2", m_rready, 1);
    check("rd0_arvalid_n2", m_arvalid, 0);
    check("rd0_rsp_valid_n2", rsp_valid, 0);
    @(negedge clk);
    check("rd0_rsp_valid_n3", rsp_valid, 1);
    check("rd0_rsp_write", rsp_write, 0);
    check("rd0_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    check("rd0_rsp_resp", rsp_resp, 0);
    check("rd0_err", err_count, 0);
    check("rd0_cmd_ready_n3", cmd_ready, 0);
    @(negedge clk);
    check("rd0_rsp_valid_n4", rsp_valid, 0);
    check("rd0_cmd_ready_n4", cmd_ready, 1);

    // Write 0x040 then read it back
    do_cmd(1'b1, 12'h040, 32'h12345678, 4'hF, lat);
    check("wr40_latency", lat, 3);
    check("wr40_rsp_write", rsp_write, 1);
    check("wr40_rsp_rdata", rsp_rdata, 0);
    check("wr40_rsp_resp", rsp_resp, 0);
    @(negedge clk);
    do_cmd(1'b0, 12'h040, 32'h0, 4'h0, lat);
    check("rd40_latency", lat, 3);
    check("rd40_rsp_write", rsp_write, 0);
    check("rd40_rsp_rdata", rsp_rdata, 32'h12345678);
    @(negedge clk);

    // AW readied two cycles before W; partial strobe into 0x044
    aw_lat = 0; w_lat = 2;
    cnt0 = b_hs_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h044;
    cmd_wdata = 32'hA5A5_0F0F; cmd_wstrb = 4'b0011;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("split_awvalid_n1", m_awvalid, 1);
    check("split_wvalid_n1", m_wvalid, 1);
    check("split_awaddr_n1", m_awaddr, 12'h044);
    @(negedge clk);
    check("split_awvalid_n2", m_awvalid, 0);
    check("split_wvalid_n2", m_wvalid, 1);
    check("split_wdata_n2", m_wdata, 32'hA5A5_0F0F);
    @(negedge clk);
    check("split_wvalid_n3", m_wvalid, 1);
    check("split_bready_n3", m_bready, 0);
    @(negedge clk);
    check("split_wvalid_n4", m_wvalid, 0);
    check("split_bready_n4", m_bready, 1);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("split_rsp_valid", rsp_valid, 1);
    check("split_rsp_write", rsp_write, 1);
    check("split_b_count", b_hs_cnt - cnt0, 1);
    @(negedge clk);
    check("split_rsp_done", rsp_valid, 0);
    repeat (3) @(negedge clk);
    check("split_b_count_later", b_hs_cnt - cnt0, 1);
    w_lat = 0;
    do_cmd(1'b0, 12'h044, 32'h0, 4'h0, lat);
    check("split_readback", rsp_rdata, 32'h0000_0F0F);
    @(negedge clk);

    // SLVERR reads: 2-bit counter goes 1,2,3 then saturates at 3
    rresp_cfg = 2'b10;
    do_cmd(1'b0, 12'h000, 32'h0, 4'h0, lat);
    check("err1_resp", rsp_resp, 2'b10);
    check("err1_count", err_count, 1);
    @(negedge clk);
    do_cmd(1'b0, 12'h000, 32'h0, 4'h0, lat);
    check("err2_count", err_count, 2);
    @(negedge clk);
    do_cmd(1'b0, 12'h000, 32'h0, 4'h0, lat);
    check("err3_count", err_count, 3);
    @(negedge clk);
    do_cmd(1'b0, 12'h000, 32'h0, 4'h0, lat);
    check("err4_rdata", rsp_rdata, 32'hDEADBEEF);
    check("err4_count_sat", err_count, 3);
    @(negedge clk);
    rresp_cfg = 2'b00;

    // Response back-pressure: hold rsp_ready low for 10 cycles
    rsp_ready = 1'b0;
    do_cmd(1'b0, 12'h040, 32'h0, 4'h0, lat);
    cnt0 = ar_hs_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_rdata", rsp_rdata, 32'h12345678);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_axi_valids", {m_arvalid, m_awvalid, m_wvalid}, 0);
    end
    check("hold_no_ar", ar_hs_cnt - cnt0, 0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("hold_rel_rsp_valid", rsp_valid, 0);
    check("hold_rel_cmd_ready", cmd_ready, 1);

    // Reset asserted while AW/W are pending
    aw_lat = 100; w_lat = 100;
    cnt0 = rsp_hs_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h048;
    cmd_wdata = 32'hCAFE_F00D; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_awvalid", m_awvalid, 1);
    #1 aresetn = 1'b0;
    #1;
    check("mid_rst_awvalid", m_awvalid, 0);
    check("mid_rst_wvalid", m_wvalid, 0);
    check("mid_rst_err", err_count, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    aresetn = 1'b1;
    aw_lat = 0; w_lat = 0;
    #1;
    check("mid_rel_cmd_ready", cmd_ready, 1);
    check("mid_rel_rsp_valid", rsp_valid, 0);
    check("mid_rel_rsp_rdata", rsp_rdata, 0);
    repeat (4) @(negedge clk);
    check("mid_no_stale_rsp", rsp_valid, 0);
    check("mid_no_rsp_hs", rsp_hs_cnt - cnt0, 0);
    do_cmd(1'b0, 12'h040, 32'h0, 4'h0, lat);
    check("post_rst_rdata", rsp_rdata, 32'h12345678);
    check("post_rst_latency", lat, 3);
    check("post_rst_err", err_count, 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
